// File: rtl/bp_pkg.sv
// bp_pkg: shared widths and entry layout for the branch resolve queue.
package bp_pkg;
  localparam int PC_W = 10;
  localparam int HIST_W = 12;
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              taken;
    logic [HIST_W-1:0] ghist;
  } brq_entry_t;
endpackage

// File: rtl/brq_sat_counter.sv
// brq_sat_counter: 16-bit increment-enable counter that holds at all-ones.
module brq_sat_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_inc,
  output logic [15:0] o_cnt
);
  logic [15:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_inc && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order queue of branch predictions; emits training
// updates at resolution and a flush/history-restore pulse on mispredict.
module branch_resolve_queue #(
  parameter int DEPTH  = 8,
  parameter int PC_W   = bp_pkg::PC_W,
  parameter int HIST_W = bp_pkg::HIST_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    pred_valid,
  output logic                    pred_ready,
  input  logic [PC_W-1:0]         pred_pc,
  input  logic                    pred_taken,
  input  logic [HIST_W-1:0]       pred_ghist,
  input  logic                    res_valid,
  input  logic                    res_taken,
  output logic                    upd_valid,
  output logic [PC_W-1:0]         upd_pc,
  output logic                    upd_taken,
  output logic                    upd_mispredict,
  output logic [HIST_W-1:0]       upd_ghist,
  output logic                    flush,
  output logic [$clog2(DEPTH):0]  count,
  output logic [15:0]             branch_cnt,
  output logic [15:0]             mispredict_cnt,
  output logic                    underflow
);
  import bp_pkg::brq_entry_t;
  localparam int AW = $clog2(DEPTH);
  brq_entry_t  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  brq_entry_t  w_head;
  logic        w_pop, w_push, w_mis;
  assign count      = r_wr_ptr - r_rd_ptr;
  assign pred_ready = count != (AW+1)'(DEPTH);
  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
  assign w_pop      = res_valid && count != '0;
  assign w_mis      = w_pop && (res_taken != w_head.taken);
  // a mispredict discards everything younger, including a same-cycle push
  assign w_push     = pred_valid && pred_ready && !w_mis;
  always_ff @(posedge clock)
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= '{pc: pred_pc, taken: pred_taken, ghist: pred_ghist};
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      upd_valid      <= 1'b0;
      upd_pc         <= '0;
      upd_taken      <= 1'b0;
      upd_mispredict <= 1'b0;
      upd_ghist      <= '0;
      flush          <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      r_rd_ptr       <= r_rd_ptr + (AW+1)'(w_pop);
      r_wr_ptr       <= w_mis ? r_rd_ptr + (AW+1)'(1) : r_wr_ptr + (AW+1)'(w_push);
      upd_valid      <= w_pop;
      upd_mispredict <= w_mis;
      flush          <= w_mis;
      underflow      <= underflow | (res_valid && count == '0);
      if (w_pop) begin
        upd_pc    <= w_head.pc;
        upd_taken <= res_taken;
        upd_ghist <= w_head.ghist;
      end
    end
  brq_sat_counter u_br_cnt  (.clk(clock), .rst_n(reset), .i_inc(w_pop), .o_cnt(branch_cnt));
  brq_sat_counter u_mis_cnt (.clk(clock), .rst_n(reset), .i_inc(w_mis), .o_cnt(mispredict_cnt));
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed self-checking bench for branch_resolve_queue.
module tb_branch_resolve_queue;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pred_valid = 1'b0, pred_taken = 1'b0, res_valid = 1'b0, res_taken = 1'b0;
  logic [9:0]  pred_pc = '0;
  logic [11:0] pred_ghist = '0;
  logic        pred_ready, upd_valid, upd_taken, upd_mispredict, flush, underflow;
  logic [9:0]  upd_pc;
  logic [11:0] upd_ghist;
  logic [3:0]  count;
  logic [15:0] branch_cnt, mispredict_cnt;
  int          n_cmp = 0, n_err = 0;
  typedef struct packed {logic [9:0] pc; logic t; logic [11:0] g;} ent_t;
  ent_t        q[$];
  ent_t        e;

  branch_resolve_queue #(.DEPTH(8)) dut (
    .clock(clock), .reset(reset), .pred_valid(pred_valid), .pred_ready(pred_ready),
    .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_ghist(pred_ghist),
    .res_valid(res_valid), .res_taken(res_taken), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .upd_ghist(upd_ghist), .flush(flush), .count(count), .branch_cnt(branch_cnt),
    .mispredict_cnt(mispredict_cnt), .underflow(underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [9:0] pc, input logic pt, input logic [11:0] gh,
                       input logic rv, input logic rt);
    pred_valid = pv; pred_pc = pc; pred_taken = pt; pred_ghist = gh;
    res_valid = rv; res_taken = rt;
    tick();
  endtask

  initial begin
    tick(); tick();
    chk("rst_upd_valid", 32'(upd_valid), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_branch_cnt", 32'(branch_cnt), 0);
    chk("rst_mis_cnt", 32'(mispredict_cnt), 0);
    chk("rst_underflow", 32'(underflow), 0);
    chk("rst_upd_pc", 32'(upd_pc), 0);
    reset = 1'b1;
    tick();
    chk("rst_ready", 32'(pred_ready), 1);

    // three correct predictions
    drive(1, 10'h004, 1, 12'h111, 0, 0);
    drive(1, 10'h008, 0, 12'h222, 0, 0);
    drive(1, 10'h00C, 1, 12'h333, 0, 0);
    pred_valid = 0;
    chk("t1_count3", 32'(count), 3);
    drive(0, 0, 0, 0, 1, 1);
    chk("t1_v0", 32'(upd_valid), 1);
    chk("t1_pc0", 32'(upd_pc), 32'h004);
    chk("t1_gh0", 32'(upd_ghist), 32'h111);
    chk("t1_mis0", 32'(upd_mispredict), 0);
    drive(0, 0, 0, 0, 1, 0);
    chk("t1_pc1", 32'(upd_pc), 32'h008);
    chk("t1_tk1", 32'(upd_taken), 0);
    chk("t1_mis1", 32'(upd_mispredict), 0);
    drive(0, 0, 0, 0, 1, 1);
    chk("t1_pc2", 32'(upd_pc), 32'h00C);
    chk("t1_flush2", 32'(flush), 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("t1_vidle", 32'(upd_valid), 0);
    chk("t1_bcnt", 32'(branch_cnt), 3);
    chk("t1_mcnt", 32'(mispredict_cnt), 0);
    chk("t1_count0", 32'(count), 0);

    // fill, full-with-pop, then wrap
    for (int i = 0; i < 8; i++) begin
      e = '{pc: 10'(10'h100 + 4*i), t: i[0], g: 12'(i)};
      q.push_back(e);
      drive(1, e.pc, e.t, e.g, 0, 0);
    end
    pred_valid = 0;
    chk("t2_full_count", 32'(count), 8);
    chk("t2_full_ready", 32'(pred_ready), 0);
    e = q.pop_front();
    pred_valid = 1; pred_pc = 10'h1F0; pred_taken = 1; pred_ghist = 12'hFFF;
    res_valid = 1; res_taken = e.t;
    #1 chk("t2_ready_pop", 32'(pred_ready), 0);
    tick();
    chk("t2_rej_pc", 32'(upd_pc), 32'(e.pc));
    chk("t2_rej_count", 32'(count), 7);
    for (int k = 0; k < 16; k++) begin
      e = '{pc: 10'(10'h200 + 4*k), t: k[0], g: 12'(12'h800 + k)};
      q.push_back(e);
      e = q.pop_front();
      drive(1, 10'(10'h200 + 4*k), k[0], 12'(12'h800 + k), 1, e.t);
      chk("t2_wrap_pc", 32'(upd_pc), 32'(e.pc));
      chk("t2_wrap_gh", 32'(upd_ghist), 32'(e.g));
      chk("t2_wrap_count", 32'(count), 7);
    end
    while (q.size() != 0) begin
      e = q.pop_front();
      drive(0, 0, 0, 0, 1, e.t);
      chk("t2_drain_pc", 32'(upd_pc), 32'(e.pc));
      chk("t2_drain_mis", 32'(upd_mispredict), 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("t2_count0", 32'(count), 0);
    chk("t2_bcnt", 32'(branch_cnt), 27);

    // mispredict flush with a dropped same-cycle push
    drive(1, 10'h010, 1, 12'hA10, 0, 0);
    drive(1, 10'h014, 0, 12'hA14, 0, 0);
    drive(1, 10'h018, 1, 12'hA18, 0, 0);
    drive(1, 10'h01C, 1, 12'hA1C, 1, 0);
    chk("t3_mis", 32'(upd_mispredict), 1);
    chk("t3_flush", 32'(flush), 1);
    chk("t3_pc", 32'(upd_pc), 32'h010);
    chk("t3_gh", 32'(upd_ghist), 32'hA10);
    chk("t3_count0", 32'(count), 0);
    drive(1, 10'h020, 1, 12'hB20, 0, 0);
    chk("t3_flush_once", 32'(flush), 0);
    chk("t3_v_once", 32'(upd_valid), 0);
    chk("t3_count1", 32'(count), 1);
    drive(0, 0, 0, 0, 1, 1);
    chk("t3_after_pc", 32'(upd_pc), 32'h020);
    chk("t3_after_mis", 32'(upd_mispredict), 0);
    chk("t3_mcnt", 32'(mispredict_cnt), 1);
    chk("t3_bcnt", 32'(branch_cnt), 29);

    // underflow
    drive(0, 0, 0, 0, 1, 1);
    chk("t4_v", 32'(upd_valid), 0);
    chk("t4_uf", 32'(underflow), 1);
    chk("t4_bcnt", 32'(branch_cnt), 29);
    drive(0, 0, 0, 0, 0, 0);
    chk("t4_uf_held", 32'(underflow), 1);

    // mispredict counter saturation
    force dut.u_mis_cnt.r_cnt = 16'hFFFD;
    #2 release dut.u_mis_cnt.r_cnt;
    drive(1, 10'h030, 1, 12'h030, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    chk("t5_m1", 32'(mispredict_cnt), 32'hFFFE);
    drive(1, 10'h034, 1, 12'h034, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    chk("t5_m2", 32'(mispredict_cnt), 32'hFFFF);
    drive(1, 10'h038, 1, 12'h038, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    chk("t5_m3_hold", 32'(mispredict_cnt), 32'hFFFF);
    chk("t5_bcnt", 32'(branch_cnt), 32);
    chk("t5_uf_held", 32'(underflow), 1);

    // asynchronous reset mid-stream
    drive(1, 10'h040, 1, 12'h040, 0, 0);
    drive(1, 10'h044, 1, 12'h044, 0, 0);
    drive(1, 10'h048, 1, 12'h048, 0, 0);
    drive(1, 10'h04C, 1, 12'h04C, 0, 0);
    pred_valid = 0;
    chk("t6_count4", 32'(count), 4);
    res_valid = 1; res_taken = 0;
    #2 reset = 1'b0;
    #1;
    chk("t6_count0", 32'(count), 0);
    chk("t6_upd_pc", 32'(upd_pc), 0);
    chk("t6_bcnt", 32'(branch_cnt), 0);
    chk("t6_mcnt", 32'(mispredict_cnt), 0);
    chk("t6_uf", 32'(underflow), 0);
    res_valid = 0;
    tick();
    chk("t6_v_in_rst", 32'(upd_valid), 0);
    reset = 1'b1;
    tick();
    chk("t6_v_after", 32'(upd_valid), 0);
    chk("t6_flush_after", 32'(flush), 0);
    chk("t6_ready", 32'(pred_ready), 1);
    chk("t6_count_after", 32'(count), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
